// File: rtl/ingress_fifo.sv
// ----------------------------------------------------------------------------
// ingress_fifo
//
// Store-and-forward packet FIFO between the link interface and the sequence
// parser. Words arrive without backpressure and are written speculatively.
// A packet becomes visible to the reader only once its last word has been
// accepted and the packet is known to be legal. Bad packets are rewound out
// of the buffer and counted. Bad means the buffer overflowed, the packet was
// too short or too long, or the length check failed.
//
// Optional feature (compile-time macro):
//   INGRESS_FIFO_LEN_CHECK_EN
//     Compare the header length field against the received word count.
//
// Parameters:
//   DEPTH      word entries (power of two, >= 16)
//   MAX_WORDS  longest accepted packet in words
//
// Ports:
//   clk            sole clock, posedge
//   reset_b        asynchronous active-low reset
//   dataIn         link word, byte 0 in [31:24]
//   dataIn_val     word present this cycle
//   dataIn_last    final word of packet (qualified by dataIn_val)
//   dataOut        head word (0 when dataOut_val=0)
//   dataOut_val    committed word available
//   dataOut_ready  downstream accepts head word
//   dataOut_last   head word ends its packet (0 when dataOut_val=0)
//   dropPulse      one-cycle pulse per discarded packet
//   dropCount      saturating count of discarded packets
// ----------------------------------------------------------------------------
module ingress_fifo #(
    parameter int DEPTH     = 64,
    parameter int MAX_WORDS = 12
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [31:0] dataIn,
    input  logic        dataIn_val,
    input  logic        dataIn_last,
    output logic [31:0] dataOut,
    output logic        dataOut_val,
    input  logic        dataOut_ready,
    output logic        dataOut_last,
    output logic        dropPulse,
    output logic [15:0] dropCount
);

    localparam int DATA_W = 32;
    localparam int AW     = $clog2(DEPTH);
    localparam int PW     = AW + 1;

    localparam logic [PW-1:0] DEPTH_P   = PW'(DEPTH);
    localparam logic [15:0]   MAX_W     = 16'(MAX_WORDS);
    localparam logic [15:0]   CNT_SAT   = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RECV    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    // Storage: {last, data}
    logic [DATA_W:0] mem [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_spec;
    logic [PW-1:0] wr_commit;
    logic [15:0]   word_cnt;
    state_t        state;
    state_t        state_nxt;

    // Decode outputs of the writer FSM
    logic wr_en;
    logic cnt_load;
    logic commit;
    logic rewind;
    logic drop_now;

    // Shared packet-legality terms
    logic [PW-1:0] occupancy;
    logic          full;
    logic [15:0]   cnt_next;
    logic          too_long;
    logic          too_short;
    logic          len_bad;
    logic          pkt_bad;
    logic          rd_fire;

    // Occupancy counts speculative words too, so an in-flight packet can
    // never overwrite committed data. Uses pre-edge pointers only.
    assign occupancy = wr_spec - rd_ptr;
    assign full      = (occupancy == DEPTH_P);

    // Count including the word presented this cycle.
    assign cnt_next  = (state == S_IDLE) ? 16'd1 : (word_cnt + 16'd1);
    assign too_long  = (cnt_next > MAX_W);
    assign too_short = dataIn_last && (cnt_next < 16'd2);

`ifdef INGRESS_FIFO_LEN_CHECK_EN
    logic        hdr_load;
    logic [15:0] hdr_len;
    logic [16:0] len_plus3;
    logic [16:0] len_words;

    // Header length is little-endian in the first two bytes of word 0.
    always_ff @(posedge clk) begin
        if (hdr_load) begin
            hdr_len <= {dataIn[23:16], dataIn[31:24]};
        end
    end

    assign len_plus3 = {1'b0, hdr_len} + 17'd3;
    assign len_words = len_plus3 >> 2;

    // Only meaningful in RECV; a last word in IDLE is already too short.
    assign len_bad = dataIn_last && (state == S_RECV) &&
                     ((hdr_len < 16'd8) || ({1'b0, cnt_next} != len_words));
`else
    assign len_bad = 1'b0;
`endif

    assign pkt_bad = full || too_long || too_short || len_bad;

    // ------------------------------------------------------------------
    // Writer FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Writer FSM: next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_RECV: begin
                if (dataIn_val) begin
                    if (dataIn_last) begin
                        state_nxt = S_IDLE;
                    end else if (pkt_bad) begin
                        state_nxt = S_DISCARD;
                    end else begin
                        state_nxt = S_RECV;
                    end
                end
            end
            S_DISCARD: begin
                if (dataIn_val && dataIn_last) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Writer FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        wr_en    = 1'b0;
        cnt_load = 1'b0;
        commit   = 1'b0;
        rewind   = 1'b0;
        drop_now = 1'b0;
`ifdef INGRESS_FIFO_LEN_CHECK_EN
        hdr_load = 1'b0;
`endif
        case (state)
            S_IDLE, S_RECV: begin
                if (dataIn_val) begin
                    if (pkt_bad) begin
                        // Rewind the partial packet; DISCARD eats the rest.
                        rewind   = 1'b1;
                        drop_now = 1'b1;
                    end else begin
                        wr_en    = 1'b1;
                        cnt_load = 1'b1;
                        commit   = dataIn_last;
`ifdef INGRESS_FIFO_LEN_CHECK_EN
                        hdr_load = (state == S_IDLE);
`endif
                    end
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Pointers, word counter, drop reporting
    // ------------------------------------------------------------------
    assign rd_fire = dataOut_val && dataOut_ready;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rd_ptr    <= '0;
            wr_spec   <= '0;
            wr_commit <= '0;
            word_cnt  <= '0;
            dropPulse <= 1'b0;
            dropCount <= '0;
        end else begin
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            if (rewind) begin
                wr_spec <= wr_commit;
            end else if (wr_en) begin
                wr_spec <= wr_spec + PW'(1);
            end

            // Commit includes the word written on this same edge.
            if (commit) begin
                wr_commit <= wr_spec + PW'(1);
            end

            if (cnt_load) begin
                word_cnt <= cnt_next;
            end

            dropPulse <= drop_now;
            if (drop_now && (dropCount != CNT_SAT)) begin
                dropCount <= dropCount + 16'd1;
            end
        end
    end

    // Storage array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_spec[AW-1:0]] <= {dataIn_last, dataIn};
        end
    end

    // ------------------------------------------------------------------
    // Read side: asynchronous head read, gated to zero when empty
    // ------------------------------------------------------------------
    logic [DATA_W:0] head;

    assign head         = mem[rd_ptr[AW-1:0]];
    assign dataOut_val  = (rd_ptr != wr_commit);
    assign dataOut      = dataOut_val ? head[DATA_W-1:0] : '0;
    assign dataOut_last = dataOut_val ? head[DATA_W] : 1'b0;

endmodule

// File: tb/tb_ingress_fifo.sv
module tb_ingress_fifo;

    localparam int DEPTH     = 16;
    localparam int MAX_WORDS = 12;

    logic        clk;
    logic        reset_b;
    logic [31:0] dataIn;
    logic        dataIn_val;
    logic        dataIn_last;
    logic [31:0] dataOut;
    logic        dataOut_val;
    logic        dataOut_ready;
    logic        dataOut_last;
    logic        dropPulse;
    logic [15:0] dropCount;

    ingress_fifo #(
        .DEPTH     (DEPTH),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk           (clk),
        .reset_b       (reset_b),
        .dataIn        (dataIn),
        .dataIn_val    (dataIn_val),
        .dataIn_last   (dataIn_last),
        .dataOut       (dataOut),
        .dataOut_val   (dataOut_val),
        .dataOut_ready (dataOut_ready),
        .dataOut_last  (dataOut_last),
        .dropPulse     (dropPulse),
        .dropCount     (dropCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: committed packets, the packet being received,
    // discard flag and drop count.
    logic [32:0] cq[$];
    logic [32:0] pq[$];
    bit          discarding = 0;
    int          exp_cnt    = 0;
    int          rdy_mode   = 1;   // 0: never ready, 1: always, 2: random

`ifdef INGRESS_FIFO_LEN_CHECK_EN
    localparam bit LEN_CHECK = 1'b1;
`else
    localparam bit LEN_CHECK = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_head();
        if (cq.size() > 0) begin
            check("out_val", 32'(dataOut_val), 32'd1);
            check("out_data", dataOut, cq[0][31:0]);
            check("out_last", 32'(dataOut_last), 32'(cq[0][32]));
        end else begin
            check("out_val", 32'(dataOut_val), 32'd0);
            check("out_data", dataOut, 32'd0);
            check("out_last", 32'(dataOut_last), 32'd0);
        end
    endtask

    // One clock cycle: present inputs, check outputs against the model,
    // advance the model, cross the edge, check the drop reporting.
    task automatic cycle(input logic v, input logic l, input logic [31:0] d);
        logic        rd;
        bit          full;
        bit          drop;
        int          n;
        logic [15:0] hl;
        logic [16:0] ew;
        rd = (rdy_mode == 1) ? 1'b1 :
             (rdy_mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        dataIn        = d;
        dataIn_val    = v;
        dataIn_last   = l;
        dataOut_ready = rd;
        #1;
        check_head();

        full = (cq.size() + pq.size()) >= DEPTH;
        drop = 0;
        if (rd && cq.size() > 0) void'(cq.pop_front());
        if (v) begin
            if (discarding) begin
                if (l) discarding = 0;
            end else begin
                n = pq.size() + 1;
                if (full || n > MAX_WORDS || (l && n < 2)) drop = 1;
                if (LEN_CHECK && l && !drop) begin
                    hl = {pq[0][23:16], pq[0][31:24]};
                    ew = (17'(hl) + 17'd3) >> 2;
                    if (hl < 16'd8 || 17'(n) != ew) drop = 1;
                end
                if (drop) begin
                    pq.delete();
                    if (exp_cnt < 65535) exp_cnt++;
                    if (!l) discarding = 1;
                end else begin
                    pq.push_back({l, d});
                    if (l) begin
                        foreach (pq[i]) cq.push_back(pq[i]);
                        pq.delete();
                    end
                end
            end
        end

        @(posedge clk);
        @(negedge clk);
        check("dropPulse", 32'(dropPulse), 32'(drop));
        check("dropCount", 32'(dropCount), 32'(exp_cnt));
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(1'b0, 1'b0, 32'd0);
    endtask

    task automatic send_pkt(input int n, input logic [15:0] hl, input bit gaps);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            if (i == 0) w[31:16] = {hl[7:0], hl[15:8]};
            if (gaps && $urandom_range(0, 3) == 0) cycle(1'b0, 1'b0, $urandom);
            cycle(1'b1, (i == n - 1), w);
        end
    endtask

    task automatic reset_mid();
        dataIn_val  = 1'b0;
        dataIn_last = 1'b0;
        reset_b     = 1'b0;
        #1;
        check("rst_out_val", 32'(dataOut_val), 32'd0);
        check("rst_out_data", dataOut, 32'd0);
        check("rst_dropCount", 32'(dropCount), 32'd0);
        check("rst_dropPulse", 32'(dropPulse), 32'd0);
        cq.delete();
        pq.delete();
        discarding = 0;
        exp_cnt    = 0;
        @(posedge clk);
        @(negedge clk);
        reset_b = 1'b1;
    endtask

    initial begin
        int          n;
        logic [15:0] hl;
        reset_b       = 1'b0;
        dataIn        = '0;
        dataIn_val    = 1'b0;
        dataIn_last   = 1'b0;
        dataOut_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_val", 32'(dataOut_val), 32'd0);
        check("reset_data", dataOut, 32'd0);
        check("reset_last", 32'(dataOut_last), 32'd0);
        check("reset_pulse", 32'(dropPulse), 32'd0);
        check("reset_count", 32'(dropCount), 32'd0);
        reset_b = 1'b1;

        // Basic 3-word packet, header length 12
        rdy_mode = 1;
        send_pkt(3, 16'd12, 0);
        idle(5);
        check("basic_no_drop", 32'(dropCount), 32'd0);

        // Overflow with the reader stalled
        rdy_mode = 0;
        send_pkt(12, 16'd48, 0);
        send_pkt(12, 16'd48, 0);
        check("ovf_count", 32'(dropCount), 32'd1);
        rdy_mode = 1;
        idle(16);

        // Single-word packet is too short
        send_pkt(1, 16'd4, 0);
        idle(3);

        // 13-word packet is too long, then a 2-word packet passes
        send_pkt(13, 16'd52, 0);
        send_pkt(2, 16'd8, 0);
        idle(4);

        // Header length 10: 4 words (fails length check), then 3 words
        send_pkt(4, 16'd10, 0);
        send_pkt(3, 16'd10, 0);
        idle(5);

        // Reset mid-packet with a committed packet buffered
        rdy_mode = 0;
        send_pkt(3, 16'd12, 0);
        cycle(1'b1, 1'b0, 32'h1000_AAAA);
        cycle(1'b1, 1'b0, 32'h5555_5555);
        reset_mid();
        rdy_mode = 1;
        send_pkt(4, 16'd16, 0);
        idle(6);

        // Randomised traffic with random backpressure
        rdy_mode = 2;
        for (int p = 0; p < 60; p++) begin
            n  = $urandom_range(1, 14);
            hl = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 60))
                                             : 16'(n * 4 - $urandom_range(0, 3));
            send_pkt(n, hl, 1);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 6));
        end
        rdy_mode = 1;
        idle(2 * DEPTH);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ingress_fifo.md
# ingress_fifo

Store-and-forward packet FIFO directly upstream of the sequence parser. It accepts a non-stallable 32-bit word stream with an end-of-packet flag from the link interface. It buffers only complete, well-formed packets and presents them to the parser with a valid/ready/last handshake. Packets that overflow the buffer, are too short or too long, or fail the optional length check are discarded whole and counted, so the parser never sees a truncated packet.

## Interface
- DEPTH, 64: word entries; power of two, at least 16.
- MAX_WORDS, 12: maximum accepted packet length in words (8-byte header plus 40 payload bytes).
- clk  input  1: sole clock; all logic on posedge.
- reset_b  input  1: asynchronous, active-low reset.
- dataIn  input  32: link word; byte 0 in [31:24].
- dataIn_val  input  1: word present this cycle; no backpressure exists.
- dataIn_last  input  1: final word of the packet, qualified by dataIn_val.
- dataOut  output  32: word at the FIFO head; reset 0; driven 0 when dataOut_val=0.
- dataOut_val  output  1: a committed word is available; reset 0.
- dataOut_ready  input  1: downstream accepts the word this cycle.
- dataOut_last  output  1: head word ends its packet; reset 0; driven 0 when dataOut_val=0.
- dropPulse  output  1: one-cycle pulse per discarded packet; reset 0.
- dropCount  output  16: discarded packets, saturating at 16'hFFFF; reset 0.

## Operation
- Storage is DEPTH x 33 bits ({last, data}).
- Pointers: rdPtr, wrSpec (speculative) and wrCommit, each log2(DEPTH)+1 bits with a wrap bit.
- Occupancy is wrSpec - rdPtr, modulo 2^(log2(DEPTH)+1). Full when occupancy == DEPTH.
- Writer FSM has three states:
  - IDLE: a valid word is written at wrSpec; wrSpec increments; wordCnt=1; header length {dataIn[23:16],dataIn[31:24]} is latched; go to RECV. If dataIn_last is also set, the packet is too short: drop it and stay in IDLE.
  - RECV: each valid word is written and wordCnt increments. On dataIn_last with a legal packet, set wrCommit <= wrSpec+1 and go to IDLE.
  - DISCARD: ignore words; on dataIn_last, go to IDLE.
- Drop conditions:
  - FIFO full when a word arrives.
  - wordCnt would exceed MAX_WORDS.
  - last word arrives with wordCnt < 2.
  - length check fails (see Configuration).
- Drop action:
  - wrSpec <= wrCommit, rewinding the partial packet.
  - dropPulse=1 for one cycle and dropCount saturating-increments, both exactly once per packet.
  - If the offending word carries dataIn_last, return straight to IDLE. Otherwise enter DISCARD.
- Reader side:
  - dataOut_val = (rdPtr != wrCommit).
  - dataOut/dataOut_last are read asynchronously from mem[rdPtr].
  - rdPtr increments when dataOut_val & dataOut_ready.
- Uncommitted words are never visible at the output.
- Simultaneous write, commit and read in one cycle is legal. Full is evaluated on the pre-edge pointers, so a read in the same cycle does not free space for that cycle's write.

## Timing
- Latency: the last word is written on edge N and dataOut_val rises after edge N (first visible cycle N+1). The earliest head-word transfer is edge N+1.
- Throughput: one word per cycle in and out, sustained.
- A word is transferred on any edge where dataOut_val & dataOut_ready. dataOut/dataOut_last hold stable while dataOut_val=1 and ready=0.
- dropPulse is registered, high the cycle after the edge that detected the drop.
- Asserting reset_b low at any time clears all pointers, the FSM (to IDLE), wordCnt, dropPulse and dropCount immediately.
  - Partial packets and buffered packets are lost and are not counted as drops.
  - Memory contents are not reset.

## Configuration
- INGRESS_FIFO_LEN_CHECK_EN defined:
  - On dataIn_last, drop the packet if the latched length is < 8 or wordCnt != (length+3)>>2.
  - The length arithmetic is 16-bit unsigned with a 17-bit intermediate for +3.
- Undefined: the header length is neither latched nor checked; only the overflow, min and max rules apply.

## Test plan
- 3-word packet (header length 12, i.e. 0x0C00_xxxx) into an empty FIFO, ready=1:
  - dataOut_val rises the cycle after the last write.
  - 3 words out with last on the third.
  - dropCount stays 0.
- Keep ready=0 with DEPTH=16 and send 12-word packets:
  - packet 1 is committed;
  - packet 2 overflows at its 5th word: dropPulse, dropCount=1, wrSpec rewound;
  - then ready=1: exactly 12 words out.
- Single-word packet (val with last) -> dropped, dropCount=1, no output.
- 13-word packet -> dropped on word 13, FSM returns to IDLE. A following 2-word packet passes intact.
- With INGRESS_FIFO_LEN_CHECK_EN, header length 10 sent in 4 words -> dropped. The same length in 3 words -> forwarded.
- Reset pulse mid-packet, with one committed packet buffered:
  - dataOut_val=0 immediately and dropCount=0.
  - The next packet is forwarded normally.
